// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
//   Central stall/flush sequencer for the 5-stage RV32I pipeline. It merges
//   four inputs into one set of pipeline controls:
//     - the load-use stall from the hazard detector
//     - instruction-fetch waits
//     - data-memory waits
//     - EX-stage redirects
//   A redirect that arrives while a fetch is outstanding is held until that
//   fetch returns. The returning wrong-path instruction is then discarded
//   instead of being latched into IF/ID.
//
//   Optional feature: define STALL_CTRL_PERF_EN to build the performance
//   counters. When it is undefined, the four counter ports are tied to 0.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   hd_stall_i               load-use stall request
//   if_req_i / if_resp_i     fetch outstanding / instruction response valid
//   mem_req_i / mem_resp_i   load/store outstanding / data response valid
//   redirect_i, redirect_pc_i  EX redirect request and target
//   pc_write_o, pc_sel_redirect_o, pc_target_o  PC register and mux control
//   *_write_o                pipeline register enables
//   if_id_flush_o, id_ex_bubble_o, fetch_discard_o  flush/bubble/discard
//   *_cnt_o                  performance counters (32-bit, wrapping)
module pipeline_stall_ctrl #(
  parameter int unsigned width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hd_stall_i,
  input  logic             if_req_i,
  input  logic             if_resp_i,
  input  logic             mem_req_i,
  input  logic             mem_resp_i,
  input  logic             redirect_i,
  input  logic [width-1:0] redirect_pc_i,
  output logic             pc_write_o,
  output logic             pc_sel_redirect_o,
  output logic [width-1:0] pc_target_o,
  output logic             if_id_write_o,
  output logic             id_ex_write_o,
  output logic             ex_mem_write_o,
  output logic             mem_wb_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic             fetch_discard_o,
  output logic [31:0]      mem_stall_cnt_o,
  output logic [31:0]      if_stall_cnt_o,
  output logic [31:0]      ld_use_cnt_o,
  output logic [31:0]      flush_cnt_o
);

  localparam int unsigned CNT_W = 32;

  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_IF_REDIR   = 2'd1;
  localparam logic [1:0] ST_REDIR_HOLD = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [width-1:0] pend_pc_q, pend_pc_d;
  logic             mem_busy, if_busy;
  logic             redir_apply, if_stall_hit, ld_use_hit;

  assign mem_busy = mem_req_i & ~mem_resp_i;
  assign if_busy  = if_req_i  & ~if_resp_i;

  // State and deferred redirect target
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_RUN;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  // Next state and combinational pipeline controls
  always_comb begin
    state_d           = state_q;
    pend_pc_d         = pend_pc_q;
    pc_write_o        = 1'b0;
    pc_sel_redirect_o = 1'b0;
    pc_target_o       = redirect_pc_i;
    if_id_write_o     = 1'b0;
    id_ex_write_o     = 1'b0;
    ex_mem_write_o    = 1'b0;
    mem_wb_write_o    = 1'b0;
    if_id_flush_o     = 1'b0;
    id_ex_bubble_o    = 1'b0;
    fetch_discard_o   = 1'b0;
    redir_apply       = 1'b0;
    if_stall_hit      = 1'b0;
    ld_use_hit        = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (mem_busy) begin
          // Whole pipe frozen; EX re-presents any redirect later.
        end else if (redirect_i && !if_busy) begin
          redir_apply = 1'b1;
        end else if (redirect_i || if_busy || hd_stall_i) begin
          // Front-end holds, a bubble enters ID/EX, and the back-end drains.
          id_ex_write_o  = 1'b1;
          ex_mem_write_o = 1'b1;
          mem_wb_write_o = 1'b1;
          id_ex_bubble_o = 1'b1;
          if_stall_hit   = if_busy;
          ld_use_hit     = !redirect_i && !if_busy;
          if (redirect_i) begin
            pend_pc_d = redirect_pc_i;
            state_d   = ST_IF_REDIR;
          end
        end else begin
          pc_write_o     = 1'b1;
          if_id_write_o  = 1'b1;
          id_ex_write_o  = 1'b1;
          ex_mem_write_o = 1'b1;
          mem_wb_write_o = 1'b1;
        end
      end

      ST_IF_REDIR: begin
        pc_target_o     = pend_pc_q;
        id_ex_bubble_o  = 1'b1;
        fetch_discard_o = if_resp_i;
        if_id_flush_o   = if_resp_i;
        if (mem_busy) begin
          if (if_resp_i) state_d = ST_REDIR_HOLD;
        end else if (if_resp_i) begin
          redir_apply = 1'b1;
          state_d     = ST_RUN;
        end else begin
          id_ex_write_o  = 1'b1;
          ex_mem_write_o = 1'b1;
          mem_wb_write_o = 1'b1;
          if_stall_hit   = if_busy;
        end
      end

      ST_REDIR_HOLD: begin
        pc_target_o = pend_pc_q;
        if (!mem_busy) begin
          redir_apply = 1'b1;
          state_d     = ST_RUN;
        end
      end

      default: state_d = ST_RUN;
    endcase

    // Applying a redirect: load PC from the mux target, flush IF/ID, bubble ID/EX.
    if (redir_apply) begin
      pc_write_o        = 1'b1;
      pc_sel_redirect_o = 1'b1;
      if_id_write_o     = 1'b1;
      id_ex_write_o     = 1'b1;
      ex_mem_write_o    = 1'b1;
      mem_wb_write_o    = 1'b1;
      if_id_flush_o     = 1'b1;
      id_ex_bubble_o    = 1'b1;
    end

    // Controls are forced quiet while reset is asserted.
    if (!rst) begin
      pc_write_o        = 1'b0;
      pc_sel_redirect_o = 1'b0;
      pc_target_o       = '0;
      if_id_write_o     = 1'b0;
      id_ex_write_o     = 1'b0;
      ex_mem_write_o    = 1'b0;
      mem_wb_write_o    = 1'b0;
      if_id_flush_o     = 1'b0;
      id_ex_bubble_o    = 1'b0;
      fetch_discard_o   = 1'b0;
    end
  end

`ifdef STALL_CTRL_PERF_EN
  logic [CNT_W-1:0] mem_stall_cnt_q, if_stall_cnt_q, ld_use_cnt_q, flush_cnt_q;

  // Performance counters, wrapping modulo 2^32
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_stall_cnt_q <= '0;
      if_stall_cnt_q  <= '0;
      ld_use_cnt_q    <= '0;
      flush_cnt_q     <= '0;
    end else begin
      if (mem_busy)     mem_stall_cnt_q <= mem_stall_cnt_q + CNT_W'(1);
      if (if_stall_hit) if_stall_cnt_q  <= if_stall_cnt_q + CNT_W'(1);
      if (ld_use_hit)   ld_use_cnt_q    <= ld_use_cnt_q + CNT_W'(1);
      if (redir_apply)  flush_cnt_q     <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign mem_stall_cnt_o = mem_stall_cnt_q;
  assign if_stall_cnt_o  = if_stall_cnt_q;
  assign ld_use_cnt_o    = ld_use_cnt_q;
  assign flush_cnt_o     = flush_cnt_q;
`else
  logic unused_perf;
  assign unused_perf     = &{1'b0, redir_apply, if_stall_hit, ld_use_hit};
  assign mem_stall_cnt_o = '0;
  assign if_stall_cnt_o  = '0;
  assign ld_use_cnt_o    = '0;
  assign flush_cnt_o     = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl
//   Directed scenarios followed by randomized traffic. All outputs are
//   compared against a flag-based reference model of the stall/redirect rules.
module tb_pipeline_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        hd_stall_i, if_req_i, if_resp_i, mem_req_i, mem_resp_i, redirect_i;
  logic [31:0] redirect_pc_i;
  logic        pc_write_o, pc_sel_redirect_o;
  logic [31:0] pc_target_o;
  logic        if_id_write_o, id_ex_write_o, ex_mem_write_o, mem_wb_write_o;
  logic        if_id_flush_o, id_ex_bubble_o, fetch_discard_o;
  logic [31:0] mem_stall_cnt_o, if_stall_cnt_o, ld_use_cnt_o, flush_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: a redirect awaiting application, and whether its
  // blocking fetch already came back (only the memory freeze remains).
  bit          m_pend;
  bit          m_fetched;
  logic [31:0] m_tgt;
  logic [31:0] c_mem, c_if, c_ld, c_fl;

  pipeline_stall_ctrl #(.width(32)) dut (
    .clk(clk), .rst(rst),
    .hd_stall_i(hd_stall_i), .if_req_i(if_req_i), .if_resp_i(if_resp_i),
    .mem_req_i(mem_req_i), .mem_resp_i(mem_resp_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .pc_write_o(pc_write_o), .pc_sel_redirect_o(pc_sel_redirect_o),
    .pc_target_o(pc_target_o),
    .if_id_write_o(if_id_write_o), .id_ex_write_o(id_ex_write_o),
    .ex_mem_write_o(ex_mem_write_o), .mem_wb_write_o(mem_wb_write_o),
    .if_id_flush_o(if_id_flush_o), .id_ex_bubble_o(id_ex_bubble_o),
    .fetch_discard_o(fetch_discard_o),
    .mem_stall_cnt_o(mem_stall_cnt_o), .if_stall_cnt_o(if_stall_cnt_o),
    .ld_use_cnt_o(ld_use_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%h exp=0x%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive inputs after the falling edge, compare the outputs against
  // the model, then advance the model on the rising edge.
  task automatic step(input bit r, input bit hd, input bit ifq, input bit ifr,
                      input bit mq, input bit mr, input bit rd, input logic [31:0] rpc);
    bit mb, ib, apply, hold_front, freeze;
    bit e_pcw, e_sel, e_ifid, e_idex, e_exmem, e_memwb, e_flush, e_bub, e_disc;
    logic [31:0] e_tgt;
    bit inc_if, inc_ld;

    @(negedge clk);
    rst = r; hd_stall_i = hd; if_req_i = ifq; if_resp_i = ifr;
    mem_req_i = mq; mem_resp_i = mr; redirect_i = rd; redirect_pc_i = rpc;
    if (!r) begin
      m_pend = 0; m_fetched = 0; m_tgt = '0;
      c_mem = '0; c_if = '0; c_ld = '0; c_fl = '0;
    end
    #1;

    mb = mq && !mr;
    ib = ifq && !ifr;
    apply = 0; hold_front = 0; freeze = 0;
    e_flush = 0; e_bub = 0; e_disc = 0;
    inc_if = 0; inc_ld = 0;
    e_tgt = m_pend ? m_tgt : rpc;

    if (!m_pend) begin
      if (mb)              freeze = 1;
      else if (rd && !ib)  apply = 1;
      else if (rd || ib || hd) begin
        hold_front = 1;
        inc_if = ib;
        inc_ld = !rd && !ib;
      end
    end else begin
      e_disc  = !m_fetched && ifr;
      e_flush = e_disc;
      e_bub   = !m_fetched;
      if (mb)                    freeze = 1;
      else if (m_fetched || ifr) apply = 1;
      else begin
        hold_front = 1;
        inc_if = ib;
      end
    end

    e_pcw   = !freeze && !hold_front;
    e_sel   = apply;
    e_ifid  = !freeze && !hold_front;
    e_idex  = !freeze;
    e_exmem = !freeze;
    e_memwb = !freeze;
    if (apply || hold_front) e_bub = 1;
    if (apply) e_flush = 1;

    if (!r) begin
      e_pcw = 0; e_sel = 0; e_ifid = 0; e_idex = 0; e_exmem = 0; e_memwb = 0;
      e_flush = 0; e_bub = 0; e_disc = 0; e_tgt = '0;
    end

    check("pc_write",     32'(pc_write_o),        32'(e_pcw));
    check("pc_sel",       32'(pc_sel_redirect_o), 32'(e_sel));
    check("pc_target",    pc_target_o,            e_tgt);
    check("if_id_write",  32'(if_id_write_o),     32'(e_ifid));
    check("id_ex_write",  32'(id_ex_write_o),     32'(e_idex));
    check("ex_mem_write", 32'(ex_mem_write_o),    32'(e_exmem));
    check("mem_wb_write", 32'(mem_wb_write_o),    32'(e_memwb));
    check("if_id_flush",  32'(if_id_flush_o),     32'(e_flush));
    check("id_ex_bubble", 32'(id_ex_bubble_o),    32'(e_bub));
    check("fetch_discard",32'(fetch_discard_o),   32'(e_disc));
`ifdef STALL_CTRL_PERF_EN
    check("mem_stall_cnt", mem_stall_cnt_o, c_mem);
    check("if_stall_cnt",  if_stall_cnt_o,  c_if);
    check("ld_use_cnt",    ld_use_cnt_o,    c_ld);
    check("flush_cnt",     flush_cnt_o,     c_fl);
`else
    check("mem_stall_cnt", mem_stall_cnt_o, 32'd0);
    check("if_stall_cnt",  if_stall_cnt_o,  32'd0);
    check("ld_use_cnt",    ld_use_cnt_o,    32'd0);
    check("flush_cnt",     flush_cnt_o,     32'd0);
`endif

    @(posedge clk);
    if (r) begin
      if (mb)     c_mem = c_mem + 32'd1;
      if (inc_if) c_if  = c_if + 32'd1;
      if (inc_ld) c_ld  = c_ld + 32'd1;
      if (apply)  c_fl  = c_fl + 32'd1;
      if (apply) begin
        m_pend = 0; m_fetched = 0;
      end else if (!m_pend && !mb && rd && ib) begin
        m_pend = 1; m_fetched = 0; m_tgt = rpc;
      end else if (m_pend && mb && ifr) begin
        m_fetched = 1;
      end
    end
  endtask

  initial begin
    rst = 1'b0; hd_stall_i = 0; if_req_i = 0; if_resp_i = 0;
    mem_req_i = 0; mem_resp_i = 0; redirect_i = 0; redirect_pc_i = '0;

    // Reset, then an immediate redirect to 0x100 with nothing busy.
    step(0, 0, 0, 0, 0, 0, 1, 32'h0000_0100);
    step(1, 0, 0, 0, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 0, 0, 1, 32'h0000_0100);

    // Redirect to 0x200 during an outstanding fetch; response arrives 3 cycles later.
    step(1, 0, 1, 0, 0, 0, 1, 32'h0000_0200);
    for (int i = 0; i < 2; i++) step(1, 0, 1, 0, 0, 0, 1, 32'h0000_0DEA);
    step(1, 0, 1, 1, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 0, 0, 0, 32'h0);

    // Deferred redirect with memory busy across the fetch response.
    step(1, 0, 1, 0, 0, 0, 1, 32'h0000_0300);
    step(1, 0, 1, 0, 1, 0, 0, 32'h0);
    step(1, 0, 1, 1, 1, 0, 0, 32'h0);
    step(1, 0, 0, 0, 1, 0, 0, 32'h0);
    step(1, 0, 0, 0, 1, 1, 0, 32'h0);
    step(1, 0, 0, 0, 0, 0, 0, 32'h0);

    // Single-cycle load-use stall.
    step(1, 1, 0, 0, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 0, 0, 0, 32'h0);

    // Memory busy for 5 cycles with the redirect held, released on response.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1, 0, 1, 32'h0000_0400);
    step(1, 0, 0, 0, 1, 1, 1, 32'h0000_0400);

    // Simultaneous instruction and data responses while a redirect is deferred.
    step(1, 0, 1, 0, 0, 0, 1, 32'h0000_0500);
    step(1, 0, 1, 1, 1, 1, 0, 32'h0);

    // Reset asserted mid-deferral drops the pending target.
    step(1, 0, 1, 0, 0, 0, 1, 32'h0000_0600);
    step(0, 0, 1, 0, 0, 0, 0, 32'h0000_0777);
    step(1, 0, 0, 1, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 0, 0, 0, 32'h0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      bit r_v;
      r_v = ($urandom_range(0, 199) != 0);
      step(r_v,
           ($urandom_range(0, 99) < 20),
           ($urandom_range(0, 99) < 55),
           ($urandom_range(0, 99) < 35),
           ($urandom_range(0, 99) < 30),
           ($urandom_range(0, 99) < 45),
           ($urandom_range(0, 99) < 25),
           $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
